// File: rtl/sys_ctrl_rx_cmd_if.sv
// Signal bundle between the RX command controller and its register file, ALU,
// RX synchronizer and TX serializer.
interface sys_ctrl_rx_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    TX_BUSY;
  logic [ADDR_WIDTH-1:0]   RF_Address;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [DATA_WIDTH-1:0]   RF_WrData;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
           ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
           ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_ctrl_rx_cmd.sv
// UART command-frame controller: decodes RX bytes into register-file and ALU
// operations and returns responses byte-by-byte over a busy-based TX handshake.
module sys_ctrl_rx_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sys_ctrl_rx_cmd_if.master bus_io
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX0,
    ST_TX1
  } state_e;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  state_e                  state_d, state_q;
  logic [ADDR_WIDTH-1:0]   rfAddr_d, rfAddr_q;
  logic [DATA_WIDTH-1:0]   rfWrData_d, rfWrData_q;
  logic                    rfWrEn_d, rfWrEn_q;
  logic                    rfRdEn_d, rfRdEn_q;
  logic                    aluEn_d, aluEn_q;
  logic [FUN_WIDTH-1:0]    aluFun_d, aluFun_q;
  logic                    clkGateEn_d, clkGateEn_q;
  logic [DATA_WIDTH-1:0]   txData_d, txData_q;
  logic                    txVld_d, txVld_q;
  logic [2*DATA_WIDTH-1:0] result_d, result_q;
  logic                    isAlu_d, isAlu_q;
  logic                    txSent_d, txSent_q;

  logic                    rxVld;
  logic [DATA_WIDTH-1:0]   rxByte;
  logic                    txBusy;

  assign rxVld  = bus_io.RX_D_VLD;
  assign rxByte = bus_io.RX_P_DATA;
  assign txBusy = bus_io.TX_BUSY;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rfAddr_q    <= '0;
      rfWrData_q  <= '0;
      rfWrEn_q    <= 1'b0;
      rfRdEn_q    <= 1'b0;
      aluEn_q     <= 1'b0;
      aluFun_q    <= '0;
      clkGateEn_q <= 1'b0;
      txData_q    <= '0;
      txVld_q     <= 1'b0;
      result_q    <= '0;
      isAlu_q     <= 1'b0;
      txSent_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rfAddr_q    <= rfAddr_d;
      rfWrData_q  <= rfWrData_d;
      rfWrEn_q    <= rfWrEn_d;
      rfRdEn_q    <= rfRdEn_d;
      aluEn_q     <= aluEn_d;
      aluFun_q    <= aluFun_d;
      clkGateEn_q <= clkGateEn_d;
      txData_q    <= txData_d;
      txVld_q     <= txVld_d;
      result_q    <= result_d;
      isAlu_q     <= isAlu_d;
      txSent_q    <= txSent_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rfAddr_d    = rfAddr_q;
    rfWrData_d  = rfWrData_q;
    rfWrEn_d    = 1'b0;
    rfRdEn_d    = 1'b0;
    aluEn_d     = 1'b0;
    aluFun_d    = aluFun_q;
    clkGateEn_d = clkGateEn_q;
    txData_d    = txData_q;
    txVld_d     = 1'b0;
    result_d    = result_q;
    isAlu_d     = isAlu_q;
    txSent_d    = txSent_q;

    case (state_q)
      ST_IDLE: begin
        if (rxVld) begin
          case (rxByte)
            CMD_WR:      state_d = ST_WR_ADDR;
            CMD_RD:      state_d = ST_RD_ADDR;
            CMD_ALU_OP: begin
              state_d     = ST_ALU_A;
              clkGateEn_d = 1'b1;
            end
            CMD_ALU_NOP: begin
              state_d     = ST_ALU_FUN;
              clkGateEn_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_WR_ADDR: begin
        if (rxVld) begin
          rfAddr_d = rxByte[ADDR_WIDTH-1:0];
          state_d  = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (rxVld) begin
          rfWrData_d = rxByte;
          rfWrEn_d   = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (rxVld) begin
          rfAddr_d = rxByte[ADDR_WIDTH-1:0];
          rfRdEn_d = 1'b1;
          state_d  = ST_RD_WAIT;
        end
      end

      // A capture with the serializer idle launches the first byte at once.
      ST_RD_WAIT: begin
        if (bus_io.RF_RdData_VLD) begin
          result_d = {{DATA_WIDTH{1'b0}}, bus_io.RF_RdData};
          isAlu_d  = 1'b0;
          state_d  = ST_TX0;
          txSent_d = !txBusy;
          if (!txBusy) begin
            txVld_d  = 1'b1;
            txData_d = bus_io.RF_RdData;
          end
        end
      end

      ST_ALU_A: begin
        if (rxVld) begin
          rfAddr_d   = ADDR_WIDTH'(0);
          rfWrData_d = rxByte;
          rfWrEn_d   = 1'b1;
          state_d    = ST_ALU_B;
        end
      end

      ST_ALU_B: begin
        if (rxVld) begin
          rfAddr_d   = ADDR_WIDTH'(1);
          rfWrData_d = rxByte;
          rfWrEn_d   = 1'b1;
          state_d    = ST_ALU_FUN;
        end
      end

      ST_ALU_FUN: begin
        if (rxVld) begin
          aluFun_d = rxByte[FUN_WIDTH-1:0];
          aluEn_d  = 1'b1;
          state_d  = ST_ALU_WAIT;
        end
      end

      ST_ALU_WAIT: begin
        if (bus_io.ALU_OUT_VLD) begin
          result_d    = bus_io.ALU_OUT;
          isAlu_d     = 1'b1;
          clkGateEn_d = 1'b0;
          state_d     = ST_TX0;
          txSent_d    = !txBusy;
          if (!txBusy) begin
            txVld_d  = 1'b1;
            txData_d = bus_io.ALU_OUT[DATA_WIDTH-1:0];
          end
        end
      end

      // Leave only once the serializer has raised busy for the byte just sent.
      ST_TX0: begin
        if (!txSent_q) begin
          if (!txBusy) begin
            txVld_d  = 1'b1;
            txData_d = result_q[DATA_WIDTH-1:0];
            txSent_d = 1'b1;
          end
        end else if (txBusy) begin
          txSent_d = 1'b0;
          state_d  = isAlu_q ? ST_TX1 : ST_IDLE;
        end
      end

      ST_TX1: begin
        if (!txSent_q) begin
          if (!txBusy) begin
            txVld_d  = 1'b1;
            txData_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
            txSent_d = 1'b1;
          end
        end else if (txBusy) begin
          txSent_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_io.RF_Address  = rfAddr_q;
  assign bus_io.RF_WrData   = rfWrData_q;
  assign bus_io.RF_WrEn     = rfWrEn_q;
  assign bus_io.RF_RdEn     = rfRdEn_q;
  assign bus_io.ALU_EN      = aluEn_q;
  assign bus_io.ALU_FUN     = aluFun_q;
  assign bus_io.CLK_GATE_EN = clkGateEn_q;
  assign bus_io.TX_P_DATA   = txData_q;
  assign bus_io.TX_D_VLD    = txVld_q;

endmodule
